hd_kernel_scheduler: RTL and testbench
======================================

Name: hd_kernel_scheduler

Overview:
- Sequencing and arbitration controller for one shared combinational 32-in/16-out arithmetic kernel of the hd benchmark family.
- Multiple requesters submit 32-bit operands; the block grants them round-robin and drives the operand to the kernel.
- It holds the operand stable for a fixed settle time, captures the 16-bit result, and returns it tagged with the requester id.
- It sits between requester logic and the kernel instance; the kernel itself is external.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand width fed to kernel
RES_W, 16, kernel result width
KERNEL_LAT, 1, cycles operand is held before result is sampled (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data  in  NUM_REQ*DATA_W  operands, requester i at bits [i*DATA_W +: DATA_W]
k_operand  out  DATA_W  operand to shared kernel
k_active  out  1  high while kernel evaluation is in progress
k_result  in  RES_W  kernel output
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  RES_W  captured kernel result
rsp_id  out  clog2(NUM_REQ)  requester index of response
busy  out  1  state != IDLE
done_cnt  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). Asserting rst_n low at any time clears state to IDLE, rr_ptr=0, operand/result/id registers=0, counter=0. All outputs read 0. An in-flight operation is dropped without a response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: the first i with req_valid[i]=1, searching upward from rr_ptr with wrap.
  - req_ready[i]=1 only for the granted i. All req_ready are 0 outside IDLE.
  - On handshake: latch req_data[i] into op_reg, latch i into id_reg, set rr_ptr=(i+1) mod NUM_REQ, load lat_cnt=KERNEL_LAT-1, go to EXEC.
  - No valid requests: stay in IDLE with rr_ptr unchanged.
- EXEC:
  - k_operand=op_reg. It is op_reg in every state, so it stays stable; k_active=1.
  - If lat_cnt==0: capture k_result into rsp_data and go to RESP. Otherwise decrement lat_cnt.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id are held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: done_cnt+=1 (wraps), return to IDLE. No new grant is made in that same cycle.
- Latency: with handshake in cycle 0, rsp_valid rises in cycle KERNEL_LAT+1. Minimum issue interval is KERNEL_LAT+2 cycles.
- Requester-side rule: req_data and req_valid may change freely while not granted. The block never samples a request outside IDLE.
- Simultaneous requests:
  - Strict rotation; no requester waits more than NUM_REQ-1 grants.
  - Back-to-back requests from the same single requester are accepted every issue interval.
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely, with outputs stable and no new grants.
- Counter at all-ones wraps to 0 on the next completion.

Decomposition:
- Shared package holds the state encoding enum (IDLE/EXEC/RESP), the default widths (DATA_W=32, RES_W=16), and a clog2-based ID_W helper constant.
- One natural sub-module: hd_rr_arbiter (NUM_REQ-wide rotating-priority one-hot grant from req vector and rr_ptr; purely combinational). The FSM, latency counter and datapath registers stay in the top.

Test Plan:
Bench kernel stub: k_result = k_operand[15:0] ^ 16'hFFFF.
1. Single request: KERNEL_LAT=1, req_valid=4'b0001, req_data[0]=32'h0000_1234, rsp_ready=1. Required: req_ready[0] high in cycle 0; rsp_valid in cycle 2 with rsp_data=16'hEDCB, rsp_id=0; done_cnt=1.
2. All four request continuously, operands 0x1,0x2,0x3,0x4. Required: grants in order 0,1,2,3,0. Responses 16'hFFFE, FFFD, FFFC, FFFB, each 3 cycles apart.
3. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. Required: rsp_data/rsp_id stable, req_ready all 0, busy=1. Then rsp_ready=1 gives one completion; a new grant follows in the next cycle only.
4. KERNEL_LAT=3, operand 32'hFFFF_0000. Required: k_active high for exactly 3 cycles, k_operand stable throughout, rsp_valid in cycle 4 with rsp_data=16'hFFFF.
5. Reset mid-EXEC: drop rst_n asynchronously during EXEC. Required: outputs 0 immediately, no response after release. The next request to requester 2 with rr_ptr=0 is granted as the lowest valid index.
6. Counter wrap: preload via 65536 completions, or use CNT_W=4 and 16 completions. Required: done_cnt returns to 0.

Source files
------------

// File: rtl/hd_kernel_scheduler_pkg.sv
// Shared types and defaults for the hd kernel scheduler slice.
// Holds the FSM state encoding, default widths and the id-width helper.
package hd_kernel_scheduler_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RES_W   = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hd_kernel_scheduler_arb.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or above ptr, with wrap.
module hd_rr_arbiter
  import hd_kernel_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hd_kernel_scheduler.sv
// Arbitrates requesters onto one shared combinational kernel, holds the operand for
// KERNEL_LAT cycles, captures the result and returns it tagged with the requester id.
module hd_kernel_scheduler
  import hd_kernel_scheduler_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int RES_W      = DEF_RES_W,
  parameter  int KERNEL_LAT = 1,
  parameter  int CNT_W      = 16,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [DATA_W-1:0]         k_operand,
  output logic                      k_active,
  input  logic [RES_W-1:0]          k_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RES_W-1:0]          rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          done_cnt
);

  localparam int LAT_W = (KERNEL_LAT > 1) ? $clog2(KERNEL_LAT) : 1;

  state_t            state_q,  state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q,     id_d;
  logic [DATA_W-1:0] op_q,     op_d;
  logic [RES_W-1:0]  res_q,    res_d;
  logic [LAT_W-1:0]  lat_q,    lat_d;
  logic [CNT_W-1:0]  done_q,   done_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  hd_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_d     = op_q;
    res_d    = res_q;
    lat_d    = lat_q;
    done_d   = done_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          op_d     = req_data[grant_idx*DATA_W +: DATA_W];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          lat_d    = LAT_W'(KERNEL_LAT - 1);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (lat_q == '0) begin
          res_d   = k_result;
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done_d  = done_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_q     <= '0;
      res_q    <= '0;
      lat_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      res_q    <= res_d;
      lat_q    <= lat_d;
      done_q   <= done_d;
    end
  end

  // The grant is combinational, so it is masked by rst_n to keep every output at 0 during reset.
  assign req_ready = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign k_operand = op_q;
  assign k_active  = (state_q == ST_EXEC);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = res_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != ST_IDLE);
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_hd_kernel_scheduler.sv
// Directed bench for hd_kernel_scheduler: a KERNEL_LAT=1/CNT_W=4 instance for most
// sequences and a KERNEL_LAT=3 instance for the long-settle case.
module tb_hd_kernel_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [31:0]  k_operand;
  logic         k_active;
  logic [15:0]  k_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [15:0]  rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;
  logic [3:0]   done_cnt;

  logic [3:0]   v3;
  logic [3:0]   ready3;
  logic [127:0] d3;
  logic [31:0]  kop3;
  logic         kact3;
  logic [15:0]  kres3;
  logic         rv3;
  logic         rdy3;
  logic [15:0]  rdata3;
  logic [1:0]   rid3;
  logic         busy3;
  logic [15:0]  done3;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] DATA4 = {32'h4, 32'h3, 32'h2, 32'h1};

  assign k_result = k_operand[15:0] ^ 16'hFFFF;
  assign kres3    = kop3[15:0] ^ 16'hFFFF;

  hd_kernel_scheduler #(
    .NUM_REQ (4), .DATA_W (32), .RES_W (16), .KERNEL_LAT (1), .CNT_W (4)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_data (req_data),
    .k_operand (k_operand), .k_active (k_active), .k_result (k_result),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
    .rsp_id (rsp_id), .busy (busy), .done_cnt (done_cnt)
  );

  hd_kernel_scheduler #(
    .NUM_REQ (4), .DATA_W (32), .RES_W (16), .KERNEL_LAT (3), .CNT_W (16)
  ) dut3 (
    .clk (clk), .rst_n (rst_n),
    .req_valid (v3), .req_ready (ready3), .req_data (d3),
    .k_operand (kop3), .k_active (kact3), .k_result (kres3),
    .rsp_valid (rv3), .rsp_ready (rdy3), .rsp_data (rdata3),
    .rsp_id (rid3), .busy (busy3), .done_cnt (done3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  exp_ready;
    logic        exp_rv;
    logic [15:0] exp_data;
    logic [1:0]  exp_id;
    logic        exp_busy;
    logic        exp_kact;
    logic [3:0]  exp_done;
  } vec_t;

  vec_t vecs [16];

  task automatic applyStimulus(input logic [3:0] v, input logic [127:0] d, input logic rdy);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    rsp_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_ready, input logic e_rv,
                             input logic [15:0] e_data, input logic [1:0] e_id,
                             input logic e_busy, input logic e_kact, input logic [3:0] e_done);
    logic [28:0] act;
    logic [28:0] exp;
    #1;
    act = {req_ready, rsp_valid, (e_rv ? rsp_data : 16'h0), (e_rv ? rsp_id : 2'd0),
           busy, k_active, done_cnt};
    exp = {e_ready, e_rv, e_data, e_id, e_busy, e_kact, e_done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got ready/rv/data/id/busy/kact/done=%h required %h", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  initial begin
    // Round-robin over four continuous requesters: grants 0,1,2,3,0 every three cycles.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 4'd0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'hFFFE, 2'd0, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd1};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 4'd1};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'hFFFD, 2'd1, 1'b1, 1'b0, 4'd1};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd2};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 4'd2};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'hFFFC, 2'd2, 1'b1, 1'b0, 4'd2};
    vecs[9]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd3};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 4'd3};
    vecs[11] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'hFFFB, 2'd3, 1'b1, 1'b0, 4'd3};
    vecs[12] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd4};
    vecs[13] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b1, 4'd4};
    vecs[14] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 16'hFFFE, 2'd0, 1'b1, 1'b0, 4'd4};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 4'd5};

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = DATA4;
    rsp_ready = 1'b1;
    v3        = 4'b0000;
    d3        = '0;
    rdy3      = 1'b1;

    // Reset state, with requests pending to show the grant is masked.
    repeat (2) @(negedge clk);
    #1;
    checkValue("reset_outputs",
               {28'h0, req_ready, rsp_valid, busy, k_active, done_cnt, rsp_data, rsp_id},
               64'h0);
    checkValue("reset_operand", {32'h0, k_operand}, 64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    // Long settle on the KERNEL_LAT=3 instance.
    @(negedge clk);
    v3 = 4'b0001;
    d3 = {96'h0, 32'hFFFF_0000};
    #1;
    checkValue("t4_grant", {60'h0, ready3}, {60'h0, 4'b0001});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      v3 = 4'b0000;
      #1;
      checkValue("t4_exec", {30'h0, kact3, rv3, kop3}, {30'h0, 1'b1, 1'b0, 32'hFFFF_0000});
    end
    @(negedge clk);
    #1;
    checkValue("t4_resp", {28'h0, kact3, rv3, rid3, rdata3, busy3},
               {28'h0, 1'b0, 1'b1, 2'd0, 16'hFFFF, 1'b1});
    @(negedge clk);
    #1;
    checkValue("t4_done", {44'h0, kact3, busy3, rv3, done3}, {44'h0, 3'b000, 16'd1});

    // Single request from requester 0.
    applyStimulus(4'b0001, {96'h0, 32'h0000_1234}, 1'b1);
    checkOutput("t1_grant", 4'b0001, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0000, {96'h0, 32'h0000_1234}, 1'b1);
    checkOutput("t1_exec", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1, 4'd0);
    applyStimulus(4'b0000, {96'h0, 32'h0000_1234}, 1'b1);
    checkOutput("t1_resp", 4'b0000, 1'b1, 16'hEDCB, 2'd0, 1'b1, 1'b0, 4'd0);
    applyStimulus(4'b0000, {96'h0, 32'h0000_1234}, 1'b1);
    checkOutput("t1_done", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid, DATA4, vecs[i].rdy);
      checkOutput("t2_table", vecs[i].exp_ready, vecs[i].exp_rv, vecs[i].exp_data,
                  vecs[i].exp_id, vecs[i].exp_busy, vecs[i].exp_kact, vecs[i].exp_done);
    end

    // Backpressure: rr_ptr=1, done=5; requester 2 is served and held in RESP.
    applyStimulus(4'b0100, DATA4, 1'b0);
    checkOutput("t3_grant", 4'b0100, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd5);
    applyStimulus(4'b1111, DATA4, 1'b0);
    checkOutput("t3_exec", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1, 4'd5);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b1111, DATA4, 1'b0);
      checkOutput("t3_hold", 4'b0000, 1'b1, 16'hFFFC, 2'd2, 1'b1, 1'b0, 4'd5);
    end
    applyStimulus(4'b1111, DATA4, 1'b1);
    checkOutput("t3_release", 4'b0000, 1'b1, 16'hFFFC, 2'd2, 1'b1, 1'b0, 4'd5);
    applyStimulus(4'b1111, DATA4, 1'b1);
    checkOutput("t3_next_grant", 4'b1000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd6);
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t3_exec2", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1, 4'd6);
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t3_resp2", 4'b0000, 1'b1, 16'hFFFB, 2'd3, 1'b1, 1'b0, 4'd6);
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t3_idle", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd7);

    // Asynchronous reset in the middle of EXEC drops the operation.
    applyStimulus(4'b0100, DATA4, 1'b1);
    checkOutput("t5_grant", 4'b0100, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd7);
    applyStimulus(4'b0100, DATA4, 1'b1);
    checkOutput("t5_exec", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1, 4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("t5_async_clear",
               {28'h0, req_ready, rsp_valid, busy, k_active, done_cnt, rsp_data, rsp_id},
               64'h0);
    checkValue("t5_operand_clear", {32'h0, k_operand}, 64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t5_no_resp_a", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t5_no_resp_b", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b1100, DATA4, 1'b1);
    checkOutput("t5_lowest_grant", 4'b0100, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd0);
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t5_exec2", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1, 4'd0);
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t5_resp", 4'b0000, 1'b1, 16'hFFFC, 2'd2, 1'b1, 1'b0, 4'd0);

    // Single requester back-to-back until the 4-bit counter wraps.
    for (int k = 0; k < 15; k++) begin
      applyStimulus(4'b0001, DATA4, 1'b1);
      checkOutput("t6_grant", 4'b0001, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'(1 + k));
      applyStimulus(4'b0001, DATA4, 1'b1);
      checkOutput("t6_exec", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1, 4'(1 + k));
      applyStimulus(4'b0001, DATA4, 1'b1);
      checkOutput("t6_resp", 4'b0000, 1'b1, 16'hFFFE, 2'd0, 1'b1, 1'b0, 4'(1 + k));
    end
    applyStimulus(4'b0000, DATA4, 1'b1);
    checkOutput("t6_wrap", 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
